// File: rtl/ht_tuple_sender.sv
// Hash-join tuple sender: streams the build relation, then the probe relation, into a
// hash table through two registered output ports, tagging each tuple with its key hash.
module ht_tuple_sender #(
    parameter logic [31:0] HASH_MULT = 32'h9E3779B1,
    parameter int          KEY_BITS  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,

    input  logic        s_build_valid,
    output logic        s_build_ready,
    input  logic [63:0] s_build_data,
    input  logic        s_build_last,

    input  logic        s_probe_valid,
    output logic        s_probe_ready,
    input  logic [63:0] s_probe_data,
    input  logic        s_probe_last,

    output logic        out_valid_BUILD,
    output logic [63:0] out_data_BUILD,
    output logic [31:0] out_hash_BUILD,
    output logic        out_last_processed_BUILD,
    input  logic        in_ready_BUILD,

    output logic        out_valid_PROBE,
    output logic [63:0] out_data_PROBE,
    output logic [31:0] out_hash_PROBE,
    output logic        out_last_processed_PROBE,
    output logic [63:0] out_serialnum,
    input  logic        in_ready_PROBE,

    output logic        busy,
    output logic        done,
    output logic [31:0] build_count,
    output logic [31:0] probe_count
);

    typedef enum logic [2:0] {
        IDLE, BUILD, BUILD_FLUSH, PROBE, PROBE_FLUSH, DONE
    } state_t;

    state_t      state, state_nx;
    logic [63:0] serial_cnt;
    logic        b_beat, b_hs, p_beat, p_hs, start_ok;

    // Only the low KEY_BITS of a tuple form the join key.
    function automatic logic [31:0] key_hash(input logic [63:0] d);
        logic [31:0] k;
        k = '0;
        k[KEY_BITS-1:0] = d[KEY_BITS-1:0];
        return k * HASH_MULT;
    endfunction

    assign s_build_ready = (state == BUILD) && (!out_valid_BUILD || in_ready_BUILD);
    assign s_probe_ready = (state == PROBE) && (!out_valid_PROBE || in_ready_PROBE);

    assign b_beat   = s_build_valid && s_build_ready;
    assign p_beat   = s_probe_valid && s_probe_ready;
    assign b_hs     = out_valid_BUILD && in_ready_BUILD;
    assign p_hs     = out_valid_PROBE && in_ready_PROBE;
    assign start_ok = start && (state == IDLE || state == DONE);

    assign busy = (state == BUILD) || (state == BUILD_FLUSH) ||
                  (state == PROBE) || (state == PROBE_FLUSH);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Flush states hold only the last-flagged beat, so its handshake ends the phase.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE:  if (start) state_nx = BUILD;
            BUILD:       if (b_beat && s_build_last) state_nx = BUILD_FLUSH;
            BUILD_FLUSH: if (b_hs && out_last_processed_BUILD) state_nx = PROBE;
            PROBE:       if (p_beat && s_probe_last) state_nx = PROBE_FLUSH;
            PROBE_FLUSH: if (p_hs && out_last_processed_PROBE) state_nx = DONE;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_BUILD          <= 1'b0;
            out_data_BUILD           <= '0;
            out_hash_BUILD           <= '0;
            out_last_processed_BUILD <= 1'b0;
        end else if (b_beat) begin
            out_valid_BUILD          <= 1'b1;
            out_data_BUILD           <= s_build_data;
            out_hash_BUILD           <= key_hash(s_build_data);
            out_last_processed_BUILD <= s_build_last;
        end else if (b_hs) begin
            out_valid_BUILD          <= 1'b0;
            out_last_processed_BUILD <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_PROBE          <= 1'b0;
            out_data_PROBE           <= '0;
            out_hash_PROBE           <= '0;
            out_last_processed_PROBE <= 1'b0;
            out_serialnum            <= '0;
        end else if (p_beat) begin
            out_valid_PROBE          <= 1'b1;
            out_data_PROBE           <= s_probe_data;
            out_hash_PROBE           <= key_hash(s_probe_data);
            out_last_processed_PROBE <= s_probe_last;
            out_serialnum            <= serial_cnt;
        end else if (p_hs) begin
            out_valid_PROBE          <= 1'b0;
            out_last_processed_PROBE <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serial_cnt  <= '0;
            build_count <= '0;
            probe_count <= '0;
        end else if (start_ok) begin
            serial_cnt  <= '0;
            build_count <= '0;
            probe_count <= '0;
        end else begin
            if (p_beat) serial_cnt <= serial_cnt + 64'd1;
            if (b_hs && build_count != 32'hFFFF_FFFF) build_count <= build_count + 32'd1;
            if (p_hs && probe_count != 32'hFFFF_FFFF) probe_count <= probe_count + 32'd1;
        end
    end

endmodule
